// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with read-valid pipeline, optional output register
// and a clear sequencer. Define RAM_SDP_BYPASS_EN for write-first collisions.
module ram_sdp_clr #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    OUT_REG    = 0,
  parameter string                 INIT_FILE  = "",
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q, clr_done_q;

  logic                  idle;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  rd_acc;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;

  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  assign idle = (state_q == S_IDLE);

  // Clear sequencer next state and sweep pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state with registered busy / done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= (state_d == S_CLEAR);
      clr_done_q <= (state_d == S_DONE);
    end
  end

  // Write port mux: the clear sweep owns the port while it runs
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = CLR_VALUE;
    end else if (idle && wr_en) begin
      mem_we    = 1'b1;
    end
  end

  // Read stage: old contents on collision unless forwarding is built in
  always_comb begin
    rd_acc     = idle && rd_en;
    s1_valid_d = rd_acc;
    s1_data_d  = s1_data_q;
    if (rd_acc) begin
      s1_data_d = mem[rd_addr];
`ifdef RAM_SDP_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) s1_data_d = wr_data;
`endif
    end
  end

  // Storage array and read data capture, no reset on either
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    s1_data_q <= s1_data_d;
  end

  // Read-valid tag of the first stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_valid_q <= 1'b0;
    else     s1_valid_q <= s1_valid_d;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

    // Extra pipeline stage, loads only on a valid result
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    // Extra stage registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign src_valid = s2_valid_q;
    assign src_data  = s2_data_q;
  end else begin : g_noreg
    assign src_valid = s1_valid_q;
    assign src_data  = s1_data_q;
  end

  // Output register holds its value between valid results
  always_comb begin
    rd_valid_d = src_valid;
    rd_data_d  = src_valid ? src_data : rd_data_q;
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Randomised bench for ram_sdp_clr: two instances (OUT_REG 0 and 1)
// share stimulus and are compared against a behavioural memory model.
module tb_ram_sdp_clr;

  localparam int DEPTH = 256;
  localparam logic [7:0] CLR = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_start;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic       busy0, busy1, done0, done1;

  always #10 clk = ~clk;

  ram_sdp_clr #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .OUT_REG(0), .CLR_VALUE(CLR)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clr_start(clr_start), .busy(busy0), .clr_done(done0)
  );

  ram_sdp_clr #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .OUT_REG(1), .CLR_VALUE(CLR)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clr_start(clr_start), .busy(busy1), .clr_done(done1)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model
  typedef enum {P_IDLE, P_CLR, P_DONE} ph_e;
  logic [7:0] mem_m [DEPTH];
  ph_e        ph;
  int         ptr;
  logic       hv [3];
  logic [7:0] hd [3];
  logic [7:0] e0d, e1d;
  int         busy_cnt, done_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    check("valid_lat1", {31'd0, rd_valid0}, {31'd0, hv[1]});
    check("data_lat1",  {24'd0, rd_data0},  {24'd0, e0d});
    check("valid_lat2", {31'd0, rd_valid1}, {31'd0, hv[2]});
    check("data_lat2",  {24'd0, rd_data1},  {24'd0, e1d});
    check("busy0", {31'd0, busy0}, {31'd0, ph == P_CLR});
    check("busy1", {31'd0, busy1}, {31'd0, ph == P_CLR});
    check("done0", {31'd0, done0}, {31'd0, ph == P_DONE});
    check("done1", {31'd0, done1}, {31'd0, ph == P_DONE});
  endtask

  task automatic model_reset();
    ph  = P_IDLE;
    ptr = 0;
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      hd[i] = 8'h00;
    end
    e0d = 8'h00;
    e1d = 8'h00;
  endtask

  // one clock edge of the specified behaviour, using pre-edge inputs
  task automatic model_edge();
    logic       rv;
    logic [7:0] rdv;
    logic       idle;
    idle = (ph == P_IDLE);
    rv   = idle && rd_en;
    rdv  = mem_m[rd_addr];
`ifdef RAM_SDP_BYPASS_EN
    if (rv && wr_en && wr_addr == rd_addr) rdv = wr_data;
`endif
    hv[2] = hv[1]; hd[2] = hd[1];
    hv[1] = hv[0]; hd[1] = hd[0];
    hv[0] = rv;    hd[0] = rdv;
    if (hv[1]) e0d = hd[1];
    if (hv[2]) e1d = hd[2];
    if (idle && wr_en) mem_m[wr_addr] = wr_data;
    case (ph)
      P_IDLE: if (clr_start) begin ph = P_CLR; ptr = 0; end
      P_CLR: begin
        mem_m[ptr] = CLR;
        if (ptr == DEPTH - 1) ph = P_DONE;
        ptr = (ptr + 1) % DEPTH;
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic step(input logic we, input logic [7:0] wa,
                      input logic [7:0] wd, input logic re,
                      input logic [7:0] ra, input logic cs);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clr_start = cs;
    @(posedge clk);
    model_edge();
    #1;
    if (busy0) busy_cnt++;
    if (done0) done_cnt++;
    check_outs();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 8'h00, 8'h00, 1'b1, a, 1'b0);
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0;

    // full clear, with accesses and a second start during busy
    busy_cnt = 0;
    done_cnt = 0;
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      if (i == 50)      step(1'b1, 8'h30, 8'h99, 1'b1, 8'h30, 1'b0);
      else if (i == 60) step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      else              idle_n(1);
    end
    check("clr_busy_len", busy_cnt, 256);
    check("clr_done_cnt", done_cnt, 1);
    rd(8'h00); rd(8'h7F); rd(8'hFF); rd(8'h30);
    idle_n(3);

    // basic write/read, streaming, collision
    wr(8'h10, 8'hA5); rd(8'h10); idle_n(3);
    wr(8'h00, 8'h11); wr(8'h01, 8'h22); wr(8'h02, 8'h33); wr(8'h03, 8'h44);
    rd(8'h00); rd(8'h01); rd(8'h02); rd(8'h03);
    idle_n(3);
    wr(8'h20, 8'h0F);
    step(1'b1, 8'h20, 8'hF0, 1'b1, 8'h20, 1'b0);
    idle_n(2);
    rd(8'h20);
    idle_n(3);

    // clear start together with a write and a read
    wr(8'h40, 8'h3C);
    step(1'b1, 8'h41, 8'hC3, 1'b1, 8'h40, 1'b1);
    idle_n(262);
    rd(8'h41);
    idle_n(3);

    // random traffic on a narrow address range
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
           8'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 1'($urandom_range(0, 299) == 0));
    end
    idle_n(270);

    // reset in the middle of a clear
    wr(8'd200, 8'h77); wr(8'd99, 8'h12); wr(8'd100, 8'h34);
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300 && ptr != 100; i++) idle_n(1);
    check("clr_ptr_reach", ptr, 100);
    do_reset();
    done_cnt = 0;
    idle_n(300);
    check("abort_no_done", done_cnt, 0);
    rd(8'd99); rd(8'd100); rd(8'd200);
    idle_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
